idu_rf_pc_brq: RTL and testbench
================================

Name: idu_rf_pc_brq

Overview:
- Parametrised next-generation PC generator for the IDU register-fetch stage.
- Holds up to 2^TAG_W resolved branch outcomes, indexed by ROB tag. The BJU may resolve branches out of order.
- Redirects the PC only when the ROB commits a taken branch. Also accepts a higher-priority trap redirect.
- Advances PC by INST_BYTES per unstalled cycle; sits between the EXU BJU result bus and the ROB commit bus.

Parameters:
XLEN, 64, PC and target width in bits.
PC_RESET, 64'h0000_0000_8000_0000, PC value after reset (XLEN bits).
INST_BYTES, 4, PC increment per unstalled cycle (1..2^(XLEN-1)).
TAG_W, 3, ROB tag width; table depth DEPTH = 2^TAG_W.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_clk  in  1  synchronous reset, active-high
y_stall_ctrl  in  1  hold PC this cycle
exu_idu_rf_bju_res_vld  in  1  BJU resolution write strobe
exu_idu_rf_bju_res_tag  in  TAG_W  ROB tag of resolved branch
exu_idu_rf_bju_res_taken  in  1  branch was taken
exu_idu_rf_bju_res_addr  in  XLEN  taken target
rob_idu_rf_br_cmt_vld  in  1  ROB commits a branch
rob_idu_rf_br_cmt_tag  in  TAG_W  tag of committing branch
rob_idu_rf_trap_vld  in  1  trap/exception redirect
rob_idu_rf_trap_addr  in  XLEN  trap vector
pc  out  XLEN  current fetch PC
pc_redirect  out  1  registered pulse: pc loaded from a redirect this cycle
brq_cnt  out  TAG_W+1  number of valid table entries
cmt_miss  out  1  registered pulse: commit found no resolved entry
res_dup  out  1  registered pulse: BJU write hit an already-valid entry

Behaviour:
- State per entry i: vld[i], taken[i], tgt[i] (XLEN).
- Reset (rst_clk=1 at edge):
  - pc=PC_RESET; all vld=0; brq_cnt=0.
  - pc_redirect, cmt_miss, res_dup = 0.
  - taken/tgt need no reset.
- PC update priority, one per cycle:
  1. reset;
  2. trap_vld: pc<=trap_addr;
  3. commit hit taken: pc<=entry target;
  4. y_stall_ctrl: pc holds;
  5. otherwise pc<=pc+INST_BYTES, truncated mod 2^XLEN (wraps silently).
- Commit lookup:
  - The entry is read from the table, with bypass: if res_vld and res_tag==cmt_tag in the same cycle, the incoming BJU data is used.
  - hit = vld (or bypass); miss = no valid entry and no bypass.
- Commit hit, taken:
  - redirect pc; clear ALL entries (younger ones are wrong-path).
  - Any other BJU write in the same cycle is dropped.
  - pc_redirect=1 next cycle.
- Commit hit, not taken:
  - clear only that entry; pc follows stall/increment.
- Commit miss:
  - no table change, no redirect; cmt_miss=1 next cycle.
- Trap:
  - clears all entries and drops any same-cycle BJU write and commit.
  - pc_redirect=1 next cycle.
- BJU write (not dropped, not consumed by bypass):
  - sets vld/taken/tgt at res_tag.
  - If the entry is already valid: overwrite and pulse res_dup next cycle.
- Same cycle BJU write and not-taken commit to different tags: both take effect.
- y_stall_ctrl does not block table writes, commits or redirects.
- brq_cnt equals popcount(vld) at all times. It is registered and updated in the same cycle as vld, max DEPTH.
- Latency: every input affects pc/table at the next rising edge. No combinational input-to-output paths.
- Reset asserted mid-operation overrides everything; the table is empty on the following cycle.

Test Plan:
- Reset, then 3 unstalled cycles with defaults -> pc 0x8000_0000, 0x8000_0004, 0x8000_0008, 0x8000_000C; brq_cnt=0.
- BJU writes tag5 taken addr 0x1000, then tag2 not-taken; commit tag2 -> brq_cnt=1, pc keeps incrementing. Commit tag5 -> next pc=0x1000, pc_redirect=1, brq_cnt=0.
- Same-cycle BJU write tag3 taken 0x2000 and commit tag3 -> bypass hit; pc=0x2000 next cycle; brq_cnt stays 0.
- Fill all 8 tags, then trap_vld with addr 0x100, y_stall_ctrl=1, and a BJU write in the same cycle -> pc=0x100, brq_cnt=0, write dropped, pc_redirect=1.
- Commit tag1 with the table empty -> cmt_miss=1 for one cycle, pc unchanged by the commit. Write tag4 twice -> res_dup=1, second target retained, brq_cnt=1.
- XLEN=32, pc=0xFFFF_FFFC, unstalled -> pc=0x0000_0000. With stall held 2 cycles, pc is stable; assert rst_clk mid-stall -> pc=PC_RESET next edge.

Source files
------------

// File: rtl/idu_rf_pc_brq.sv
// idu_rf_pc_brq: register-fetch PC generator with an out-of-order branch resolution table
//   clk, rst_clk                      clock, synchronous active-high reset
//   y_stall_ctrl                      hold pc this cycle
//   exu_idu_rf_bju_res_*              BJU resolution write (tag, taken, target)
//   rob_idu_rf_br_cmt_*               ROB branch commit (tag)
//   rob_idu_rf_trap_*                 trap redirect (highest priority)
//   pc, pc_redirect                   fetch PC and registered redirect pulse
//   brq_cnt, cmt_miss, res_dup        valid entry count and registered event pulses
module idu_rf_pc_brq #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] PC_RESET = XLEN'(64'h0000_0000_8000_0000),
  parameter int unsigned INST_BYTES = 4,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst_clk,
  input  logic             y_stall_ctrl,
  input  logic             exu_idu_rf_bju_res_vld,
  input  logic [TAG_W-1:0] exu_idu_rf_bju_res_tag,
  input  logic             exu_idu_rf_bju_res_taken,
  input  logic [XLEN-1:0]  exu_idu_rf_bju_res_addr,
  input  logic             rob_idu_rf_br_cmt_vld,
  input  logic [TAG_W-1:0] rob_idu_rf_br_cmt_tag,
  input  logic             rob_idu_rf_trap_vld,
  input  logic [XLEN-1:0]  rob_idu_rf_trap_addr,
  output logic [XLEN-1:0]  pc,
  output logic             pc_redirect,
  output logic [TAG_W:0]   brq_cnt,
  output logic             cmt_miss,
  output logic             res_dup
);
  localparam int DEPTH = 1 << TAG_W;
  logic [XLEN-1:0] pc_q, pc_d, c_tgt;
  logic [DEPTH-1:0] vld_q, vld_d, taken_q;
  logic [XLEN-1:0] tgt_q [DEPTH];
  logic [TAG_W:0] cnt_q, cnt_d;
  logic redir_q, miss_q, dup_q;
  logic bypass, hit, c_taken, flush, wr;
  always_comb begin
    bypass = exu_idu_rf_bju_res_vld && rob_idu_rf_br_cmt_vld && exu_idu_rf_bju_res_tag == rob_idu_rf_br_cmt_tag;
    hit = rob_idu_rf_br_cmt_vld && (vld_q[rob_idu_rf_br_cmt_tag] || bypass);
    c_taken = bypass ? exu_idu_rf_bju_res_taken : taken_q[rob_idu_rf_br_cmt_tag];
    c_tgt = bypass ? exu_idu_rf_bju_res_addr : tgt_q[rob_idu_rf_br_cmt_tag];
    // a taken commit or a trap squashes every younger entry, including this cycle's write
    flush = rob_idu_rf_trap_vld || (hit && c_taken);
    wr = exu_idu_rf_bju_res_vld && !flush && !bypass;
    vld_d = vld_q;
    if (flush) vld_d = '0;
    else begin
      if (hit) vld_d[rob_idu_rf_br_cmt_tag] = 1'b0;
      if (wr) vld_d[exu_idu_rf_bju_res_tag] = 1'b1;
    end
    cnt_d = (TAG_W+1)'($countones(vld_d));
    pc_d = rob_idu_rf_trap_vld ? rob_idu_rf_trap_addr :
           (hit && c_taken) ? c_tgt :
           y_stall_ctrl ? pc_q : pc_q + XLEN'(INST_BYTES);
  end
  always_ff @(posedge clk) begin
    if (rst_clk) begin
      pc_q <= PC_RESET;
      vld_q <= '0;
      cnt_q <= '0;
      redir_q <= 1'b0;
      miss_q <= 1'b0;
      dup_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      redir_q <= flush;
      miss_q <= rob_idu_rf_br_cmt_vld && !hit && !rob_idu_rf_trap_vld;
      dup_q <= wr && vld_q[exu_idu_rf_bju_res_tag];
    end
  end
  always_ff @(posedge clk) begin
    if (wr) begin
      taken_q[exu_idu_rf_bju_res_tag] <= exu_idu_rf_bju_res_taken;
      tgt_q[exu_idu_rf_bju_res_tag] <= exu_idu_rf_bju_res_addr;
    end
  end
  assign pc = pc_q;
  assign pc_redirect = redir_q;
  assign brq_cnt = cnt_q;
  assign cmt_miss = miss_q;
  assign res_dup = dup_q;
endmodule

// File: tb/tb_idu_rf_pc_brq.sv
// tb_idu_rf_pc_brq: vector-table and scoreboard bench for idu_rf_pc_brq
module tb_idu_rf_pc_brq;
  typedef struct {
    logic rst, stall, rv;
    logic [2:0] rtag;
    logic rtk;
    logic [63:0] raddr;
    logic cv;
    logic [2:0] ctag;
    logic tv;
    logic [63:0] taddr;
    logic [63:0] pc;
    logic redir;
    logic [3:0] cnt;
    logic miss, dup;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1, stall = 1'b0, rv = 1'b0, rtk = 1'b0, cv = 1'b0, tv = 1'b0;
  logic [2:0] rtag = '0, ctag = '0;
  logic [63:0] raddr = '0, taddr = '0, pc;
  logic redir, miss, dup;
  logic [3:0] cnt;
  logic r32 = 1'b1, s32 = 1'b0, tv32 = 1'b0;
  logic [31:0] ta32 = '0, pc32;
  logic redir32, miss32, dup32;
  logic [3:0] cnt32;
  vec_t vt[$];
  vec_t exp_q[$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  idu_rf_pc_brq dut (
    .clk(clk), .rst_clk(rst), .y_stall_ctrl(stall),
    .exu_idu_rf_bju_res_vld(rv), .exu_idu_rf_bju_res_tag(rtag),
    .exu_idu_rf_bju_res_taken(rtk), .exu_idu_rf_bju_res_addr(raddr),
    .rob_idu_rf_br_cmt_vld(cv), .rob_idu_rf_br_cmt_tag(ctag),
    .rob_idu_rf_trap_vld(tv), .rob_idu_rf_trap_addr(taddr),
    .pc(pc), .pc_redirect(redir), .brq_cnt(cnt), .cmt_miss(miss), .res_dup(dup)
  );
  idu_rf_pc_brq #(.XLEN(32), .PC_RESET(32'h8000_0000)) dut32 (
    .clk(clk), .rst_clk(r32), .y_stall_ctrl(s32),
    .exu_idu_rf_bju_res_vld(1'b0), .exu_idu_rf_bju_res_tag(3'd0),
    .exu_idu_rf_bju_res_taken(1'b0), .exu_idu_rf_bju_res_addr(32'd0),
    .rob_idu_rf_br_cmt_vld(1'b0), .rob_idu_rf_br_cmt_tag(3'd0),
    .rob_idu_rf_trap_vld(tv32), .rob_idu_rf_trap_addr(ta32),
    .pc(pc32), .pc_redirect(redir32), .brq_cnt(cnt32), .cmt_miss(miss32), .res_dup(dup32)
  );
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic add(input logic r, s, w, input int wt, input logic wk, input logic [63:0] wa,
                     input logic c, input int ct, input logic t, input logic [63:0] ta,
                     input logic [63:0] epc, input logic erd, input int ecnt, input logic em, ed);
    vec_t v;
    v.rst = r; v.stall = s; v.rv = w; v.rtag = 3'(wt); v.rtk = wk; v.raddr = wa;
    v.cv = c; v.ctag = 3'(ct); v.tv = t; v.taddr = ta;
    v.pc = epc; v.redir = erd; v.cnt = 4'(ecnt); v.miss = em; v.dup = ed;
    vt.push_back(v);
  endtask
  task automatic step32(input logic r, s, t, input logic [31:0] ta, input logic [31:0] epc, input logic erd, input string n);
    @(negedge clk);
    r32 = r; s32 = s; tv32 = t; ta32 = ta;
    @(posedge clk);
    #1;
    chk({n, " pc32"}, 64'(pc32), 64'(epc));
    chk({n, " redir32"}, 64'(redir32), 64'(erd));
  endtask
  initial begin
    vec_t e;
    add(1,0,0,0,0,0,      0,0,0,0,     64'h8000_0000,0,0,0,0);
    add(0,0,0,0,0,0,      0,0,0,0,     64'h8000_0004,0,0,0,0);
    add(0,0,0,0,0,0,      0,0,0,0,     64'h8000_0008,0,0,0,0);
    add(0,0,0,0,0,0,      0,0,0,0,     64'h8000_000C,0,0,0,0);
    add(0,0,1,5,1,'h1000, 0,0,0,0,     64'h8000_0010,0,1,0,0);
    add(0,0,1,2,0,0,      0,0,0,0,     64'h8000_0014,0,2,0,0);
    add(0,0,0,0,0,0,      1,2,0,0,     64'h8000_0018,0,1,0,0);
    add(0,0,0,0,0,0,      1,5,0,0,     64'h1000,1,0,0,0);
    add(0,0,1,3,1,'h2000, 1,3,0,0,     64'h2000,1,0,0,0);
    add(0,0,0,0,0,0,      0,0,0,0,     64'h2004,0,0,0,0);
    for (int i = 0; i < 8; i++)
      add(0,0,1,i,1,64'h3000 + 64'(i*16), 0,0,0,0, 64'h2008 + 64'(i*4),0,i+1,0,0);
    add(0,1,1,0,1,'hDEAD, 0,0,1,'h100, 64'h100,1,0,0,0);
    add(0,1,0,0,0,0,      0,0,0,0,     64'h100,0,0,0,0);
    add(0,0,0,0,0,0,      1,1,0,0,     64'h104,0,0,1,0);
    add(0,0,0,0,0,0,      0,0,0,0,     64'h108,0,0,0,0);
    add(0,0,1,4,1,'h4000, 0,0,0,0,     64'h10C,0,1,0,0);
    add(0,0,1,4,1,'h5000, 0,0,0,0,     64'h110,0,1,0,1);
    add(0,0,0,0,0,0,      1,4,0,0,     64'h5000,1,0,0,0);
    add(0,0,1,6,0,'h6000, 1,6,0,0,     64'h5004,0,0,0,0);
    add(0,0,1,1,1,'h7000, 0,0,0,0,     64'h5008,0,1,0,0);
    add(0,0,1,2,0,0,      1,1,0,0,     64'h7000,1,0,0,0);
    add(0,0,1,3,1,'h8000, 0,0,0,0,     64'h7004,0,1,0,0);
    add(0,0,1,5,0,0,      0,0,0,0,     64'h7008,0,2,0,0);
    add(0,0,1,0,1,'hA000, 1,5,0,0,     64'h700C,0,2,0,0);
    add(0,1,0,0,0,0,      1,0,0,0,     64'hA000,1,0,0,0);
    add(0,1,1,2,1,'hB000, 0,0,0,0,     64'hA000,0,1,0,0);
    add(1,0,1,3,1,'hC000, 0,0,0,0,     64'h8000_0000,0,0,0,0);
    add(0,0,0,0,0,0,      0,0,0,0,     64'h8000_0004,0,0,0,0);
    add(0,0,1,1,1,'hD000, 0,0,0,0,     64'h8000_0008,0,1,0,0);
    add(0,0,0,0,0,0,      1,1,1,'h200, 64'h200,1,0,0,0);
    add(0,0,0,0,0,0,      1,1,0,0,     64'h204,0,0,1,0);
    foreach (vt[i]) begin
      @(negedge clk);
      rst = vt[i].rst; stall = vt[i].stall; rv = vt[i].rv; rtag = vt[i].rtag;
      rtk = vt[i].rtk; raddr = vt[i].raddr; cv = vt[i].cv; ctag = vt[i].ctag;
      tv = vt[i].tv; taddr = vt[i].taddr;
      exp_q.push_back(vt[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("v%0d pc", i), pc, e.pc);
      chk($sformatf("v%0d pc_redirect", i), 64'(redir), 64'(e.redir));
      chk($sformatf("v%0d brq_cnt", i), 64'(cnt), 64'(e.cnt));
      chk($sformatf("v%0d cmt_miss", i), 64'(miss), 64'(e.miss));
      chk($sformatf("v%0d res_dup", i), 64'(dup), 64'(e.dup));
    end
    @(negedge clk);
    rst = 1'b0; stall = 1'b0; rv = 1'b0; cv = 1'b0; tv = 1'b0;
    step32(0,0,1,32'hFFFF_FFFC, 32'hFFFF_FFFC,1,"x32 trap");
    step32(0,0,0,32'h0,         32'h0000_0000,0,"x32 wrap");
    step32(0,1,0,32'h0,         32'h0000_0000,0,"x32 stall1");
    step32(0,1,0,32'h0,         32'h0000_0000,0,"x32 stall2");
    step32(1,1,0,32'h0,         32'h8000_0000,0,"x32 reset");
    chk("x32 brq_cnt", 64'(cnt32), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
